// File: rtl/wb_uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_uart_rx_pkg
//  Description : Shared types and constants for the Wishbone UART receiver:
//                receiver FSM state encoding, register map indices and the
//                STATUS / CTRL bit positions (mirrored by firmware headers).
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_uart_rx_pkg;

    // Bit-timing FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BRK   = 3'd4
    } rx_state_t;

    // Register index taken from wb_addr_i[3:2]
    localparam logic [1:0] c_REG_DATA   = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_CTRL   = 2'd2;
    localparam logic [1:0] c_REG_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int c_STAT_NEMPTY    = 0;
    localparam int c_STAT_FULL      = 1;
    localparam int c_STAT_OVERRUN   = 2;
    localparam int c_STAT_FRAME_ERR = 3;
    localparam int c_STAT_COUNT_LSB = 8;

    // CTRL bit positions
    localparam int c_CTRL_RX_EN  = 0;
    localparam int c_CTRL_IRQ_EN = 1;

    // DATA register word: valid flag in bit 31, received byte in the low byte
    function automatic logic [31:0] f_data_word(input logic valid, input logic [7:0] rx_byte);
        return {valid, 23'd0, rx_byte};
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_uart_rx_if
//  Description : Wishbone classic slave bus bundle for the UART receiver,
//                with master and slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_uart_rx_if #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32
);
    logic [WB_ADDR_WIDTH-1:0]   wb_addr_i;
    logic [WB_DATA_WIDTH-1:0]   wb_data_i;
    logic [WB_DATA_WIDTH/8-1:0] wb_sel_i;
    logic                       wb_we_i;
    logic                       wb_cyc_i;
    logic                       wb_stb_i;
    logic                       wb_ack_o;
    logic [WB_DATA_WIDTH-1:0]   wb_data_o;

    modport master (
        output wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_ack_o, wb_data_o
    );

    modport slave (
        input  wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_ack_o, wb_data_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_uart_rx_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_uart_rx_sync_fifo
//  Description : Single-clock FIFO with occupancy count. A pop in the same
//                cycle as a push into a full FIFO frees the slot, so the push
//                is accepted. A push into a full FIFO without a pop is dropped
//                and flagged on o_overflow for that cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_uart_rx_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  i_push,
    input  wire logic [WIDTH-1:0]      i_data,
    input  wire logic                  i_pop,
    output logic      [WIDTH-1:0]      o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic      [DEPTH_LOG2:0]   o_count,
    output logic                       o_overflow
);
    localparam int                  c_DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH_CNT = (DEPTH_LOG2 + 1)'(c_DEPTH);

    logic [WIDTH-1:0]      r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full     = (r_count == c_DEPTH_CNT);
    assign w_empty    = (r_count == '0);
    assign w_do_pop   = i_pop & ~w_empty;
    assign w_do_push  = i_push & (~w_full | w_do_pop);

    assign o_data     = r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = i_push & w_full & ~w_do_pop;

    // Storage array; written on an accepted push, never reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/wb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : wb_uart_rx
//  Description : 8N1 UART receiver with a Wishbone slave register window.
//                Synchronises the serial line, deserialises frames with a
//                bit-timing FSM, buffers bytes in a FIFO and raises a level
//                interrupt while data is waiting and interrupts are enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_uart_rx
    import wb_uart_rx_pkg::*;
#(
    parameter int WB_DATA_WIDTH   = 32,
    parameter int WB_ADDR_WIDTH   = 32,
    parameter int CLKS_PER_BIT    = 16,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  wire logic  clk_i,
    input  wire logic  rst_ni,
    wb_uart_rx_if.slave wb,
    input  wire logic  uart_rx_i,
    output logic       rx_irq_o
);
    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // Serial input synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic w_fall;

    assign w_fall = r_sync3 & ~r_sync2;

    // Two-flop synchroniser plus edge flop, idling high like the line
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx_i;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    logic r_rx_en;
    logic r_irq_en;
    logic r_overrun;
    logic r_frame_err;

    // ------------------------------------------------------------------
    // Bit-timing FSM
    // ------------------------------------------------------------------
    rx_state_t          r_state;
    logic [c_CNT_W-1:0] r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_push;
    logic               r_ferr_pulse;

    // Frame deserialiser; push and frame-error pulses are registered one-cycle strobes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_push       <= 1'b0;
            r_ferr_pulse <= 1'b0;
        end else begin
            r_push       <= 1'b0;
            r_ferr_pulse <= 1'b0;
            if (!r_rx_en) begin
                r_state    <= ST_IDLE;
                r_baud_cnt <= '0;
                r_bit_idx  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_fall) begin
                            r_state    <= ST_START;
                            r_baud_cnt <= '0;
                            r_bit_idx  <= '0;
                        end
                    end
                    ST_START: begin
                        // Mid-bit check of the start bit; a high line means a glitch
                        if (r_baud_cnt == c_HALF_LAST) begin
                            r_baud_cnt <= '0;
                            r_state    <= r_sync2 ? ST_IDLE : ST_DATA;
                        end else begin
                            r_baud_cnt <= r_baud_cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (r_baud_cnt == c_BIT_LAST) begin
                            r_baud_cnt <= '0;
                            r_shift    <= {r_sync2, r_shift[7:1]};
                            r_bit_idx  <= r_bit_idx + 1'b1;
                            if (r_bit_idx == 3'd7) begin
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_baud_cnt <= r_baud_cnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (r_baud_cnt == c_BIT_LAST) begin
                            r_baud_cnt <= '0;
                            if (r_sync2) begin
                                r_push  <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_ferr_pulse <= 1'b1;
                                r_state      <= ST_BRK;
                            end
                        end else begin
                            r_baud_cnt <= r_baud_cnt + 1'b1;
                        end
                    end
                    ST_BRK: begin
                        // Hold off new frames until the line has returned to idle
                        if (r_sync2) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]               w_fifo_data;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] w_fifo_count;
    logic                     w_fifo_ovf;
    logic                     w_pop;

    wb_uart_rx_sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .i_push     (r_push),
        .i_data     (r_shift),
        .i_pop      (w_pop),
        .o_data     (w_fifo_data),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_count),
        .o_overflow (w_fifo_ovf)
    );

    // ------------------------------------------------------------------
    // Wishbone decode
    // ------------------------------------------------------------------
    logic                     r_ack;
    logic [WB_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]               w_reg_idx;
    logic                     w_req;
    logic                     w_rd;
    logic                     w_wr;
    logic                     w_clr_ovr;
    logic                     w_clr_ferr;
    logic [WB_DATA_WIDTH-1:0] w_status;
    logic [WB_DATA_WIDTH-1:0] w_rd_data;
    logic                     w_unused_bits;

    assign w_reg_idx  = wb.wb_addr_i[3:2];
    assign w_req      = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
    assign w_rd       = w_req & ~wb.wb_we_i;
    assign w_wr       = w_req &  wb.wb_we_i;
    assign w_pop      = w_rd & (w_reg_idx == c_REG_DATA) & ~w_fifo_empty;
    assign w_clr_ovr  = w_wr & (w_reg_idx == c_REG_STATUS) & wb.wb_data_i[c_STAT_OVERRUN];
    assign w_clr_ferr = w_wr & (w_reg_idx == c_REG_STATUS) & wb.wb_data_i[c_STAT_FRAME_ERR];

    assign w_unused_bits = ^{wb.wb_sel_i, wb.wb_data_i[WB_DATA_WIDTH-1:4],
                             wb.wb_addr_i[WB_ADDR_WIDTH-1:4], wb.wb_addr_i[1:0]};

    // STATUS word assembly
    always_comb begin
        w_status                                            = '0;
        w_status[c_STAT_NEMPTY]                             = ~w_fifo_empty;
        w_status[c_STAT_FULL]                               = w_fifo_full;
        w_status[c_STAT_OVERRUN]                            = r_overrun;
        w_status[c_STAT_FRAME_ERR]                          = r_frame_err;
        w_status[c_STAT_COUNT_LSB +: FIFO_DEPTH_LOG2 + 1]   = w_fifo_count;
    end

    // Read mux; empty DATA reads return zero with the valid flag clear
    always_comb begin
        w_rd_data = '0;
        case (w_reg_idx)
            c_REG_DATA:   w_rd_data = w_fifo_empty ? '0 : f_data_word(1'b1, w_fifo_data);
            c_REG_STATUS: w_rd_data = w_status;
            c_REG_CTRL: begin
                w_rd_data[c_CTRL_RX_EN]  = r_rx_en;
                w_rd_data[c_CTRL_IRQ_EN] = r_irq_en;
            end
            default:      w_rd_data = '0;
        endcase
    end

    // Single-cycle ack, registered read data and CTRL writes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ack    <= 1'b0;
            r_rdata  <= '0;
            r_rx_en  <= 1'b1;
            r_irq_en <= 1'b0;
        end else begin
            r_ack <= w_req;
            if (w_rd) begin
                r_rdata <= w_rd_data;
            end
            if (w_wr && (w_reg_idx == c_REG_CTRL)) begin
                r_rx_en  <= wb.wb_data_i[c_CTRL_RX_EN];
                r_irq_en <= wb.wb_data_i[c_CTRL_IRQ_EN];
            end
        end
    end

    // Sticky error bits; a set in the same cycle as a clear wins
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= w_fifo_ovf   | (r_overrun   & ~w_clr_ovr);
            r_frame_err <= r_ferr_pulse | (r_frame_err & ~w_clr_ferr);
        end
    end

    // Level interrupt, one cycle behind the FIFO state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_irq_o <= 1'b0;
        end else begin
            rx_irq_o <= r_irq_en & ~w_fifo_empty;
        end
    end

    assign wb.wb_ack_o  = r_ack;
    assign wb.wb_data_o = r_rdata;
endmodule
`default_nettype wire
